// File: rtl/regfile_hc_param.sv
`default_nettype none
// ============================================================================
// Module   : regfile_hc_param
// Brief    : Hot/cold integer register file with N read ports, one write
//            port, compressed addressing, violation log and cold scrubber.
// Revision : 1.0
// ============================================================================
module regfile_hc_param #(
  parameter int                      XLEN     = 64,
  parameter int                      NREGS    = 32,
  parameter int                      NRPORTS  = 2,
  parameter logic [NREGS-1:0]        HOT_MASK = 32'h0000_0767,
  parameter bit                      BYPASS   = 1'b1,
  parameter int                      ERRW     = 8,
  localparam int                     AW       = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NRPORTS*AW-1:0]      raddr_i,
  input  logic [NRPORTS-1:0]         rvalid_i,
  output logic [NRPORTS*XLEN-1:0]    rdata_o,
  input  logic [AW-1:0]              waddr_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic                       regwrite_i,
  input  logic                       is_16_i,
  input  logic                       cold_en_i,
  input  logic                       scrub_i,
  output logic                       scrub_busy_o,
  input  logic                       err_clr_i,
  output logic                       cold_err_o,
  output logic [ERRW-1:0]            err_cnt_o,
  output logic [AW-1:0]              err_addr_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SCRUB = 1'b1;

  logic [XLEN-1:0] regs [NREGS];

  logic [0:0]      state;
  logic [0:0]      state_next;
  logic [AW-1:0]   scrub_idx;
  logic            scrub_zero;

  logic [AW-1:0]   w_eff;
  logic            w_cold;
  logic            w_commit;
  logic            w_viol;

  logic [AW-1:0]   r_eff [NRPORTS];
  logic [NRPORTS-1:0] r_viol;

  logic            viol;
  logic [AW-1:0]   viol_addr;

  // Compressed encodings address the x8..x15 window only.
  function automatic logic [AW-1:0] eff_addr(input logic [AW-1:0] a, input logic c16);
    logic [AW-1:0] e;
    if (c16) begin
      e      = '0;
      e[3]   = 1'b1;
      e[2:0] = a[2:0];
    end else begin
      e = a;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  assign w_eff    = eff_addr(waddr_i, is_16_i);
  assign w_cold   = ~HOT_MASK[w_eff];
  assign w_commit = regwrite_i && (w_eff != '0) &&
                    (!w_cold || (cold_en_i && !scrub_busy_o));
  assign w_viol   = regwrite_i && !cold_en_i && w_cold && (w_eff != '0);

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  generate
    for (genvar p = 0; p < NRPORTS; p++) begin : g_rport
      logic r_cold;
      logic r_block;
      logic r_byp;

      assign r_eff[p]  = eff_addr(raddr_i[p*AW +: AW], is_16_i);
      assign r_cold    = ~HOT_MASK[r_eff[p]];
      assign r_block   = (r_eff[p] == '0) || (r_cold && (!cold_en_i || scrub_busy_o));
      assign r_byp     = BYPASS && w_commit && (w_eff == r_eff[p]);
      assign r_viol[p] = rvalid_i[p] && !cold_en_i && r_cold && (r_eff[p] != '0);

      always_comb begin
        rdata_o[p*XLEN +: XLEN] = regs[r_eff[p]];
        if (r_block) begin
          rdata_o[p*XLEN +: XLEN] = '0;
        end else if (r_byp) begin
          rdata_o[p*XLEN +: XLEN] = wdata_i;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Register storage and scrub clearing (never collide: cold writes are
  // blocked while scrubbing and the scrubber only touches cold entries)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (w_commit) begin
        regs[w_eff] <= wdata_i;
      end
      if (scrub_zero) begin
        regs[scrub_idx] <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Violation log
  // ---------------------------------------------------------------------------
  assign viol = w_viol || (|r_viol);

  // Walk lowest priority first so the write port ends up winning.
  always_comb begin
    viol_addr = '0;
    for (int p = NRPORTS - 1; p >= 0; p--) begin
      if (r_viol[p]) begin
        viol_addr = r_eff[p];
      end
    end
    if (w_viol) begin
      viol_addr = w_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cold_err_o <= 1'b0;
      err_cnt_o  <= '0;
      err_addr_o <= '0;
    end else if (err_clr_i) begin
      cold_err_o <= viol;
      err_cnt_o  <= viol ? ERRW'(1) : '0;
      err_addr_o <= viol ? viol_addr : '0;
    end else if (viol) begin
      cold_err_o <= 1'b1;
      err_cnt_o  <= (&err_cnt_o) ? err_cnt_o : err_cnt_o + 1'b1;
      if (!cold_err_o) begin
        err_addr_o <= viol_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scrub sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (scrub_i) state_next = S_SCRUB;
      S_SCRUB: if (scrub_idx == AW'(NREGS - 1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    scrub_busy_o = (state == S_SCRUB);
    scrub_zero   = scrub_busy_o && !HOT_MASK[scrub_idx];
  end

  // x0 is never scrubbed, so the walk starts at 1 and wraps back to 0 at exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      scrub_idx <= '0;
    end else if (state == S_IDLE && scrub_i) begin
      scrub_idx <= AW'(1);
    end else if (state == S_SCRUB) begin
      scrub_idx <= scrub_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_hc_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_hc_param
// Brief    : Directed self-checking bench for regfile_hc_param.
// Revision : 1.0
// ============================================================================
module tb_regfile_hc_param;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [2*AW-1:0]   raddr;
  logic [1:0]        rvalid;
  logic [2*XLEN-1:0] rdata;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic              regwrite;
  logic              is_16;
  logic              cold_en;
  logic              scrub;
  logic              scrub_busy;
  logic              err_clr;
  logic              cold_err;
  logic [7:0]        err_cnt;
  logic [AW-1:0]     err_addr;

  int tests  = 0;
  int failed = 0;
  int busy_cycles;

  regfile_hc_param dut (
    .clk          (clk),
    .rst          (rst),
    .raddr_i      (raddr),
    .rvalid_i     (rvalid),
    .rdata_o      (rdata),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .regwrite_i   (regwrite),
    .is_16_i      (is_16),
    .cold_en_i    (cold_en),
    .scrub_i      (scrub),
    .scrub_busy_o (scrub_busy),
    .err_clr_i    (err_clr),
    .cold_err_o   (cold_err),
    .err_cnt_o    (err_cnt),
    .err_addr_o   (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; raddr = '0; rvalid = '0; waddr = '0; wdata = '0;
    regwrite = 1'b0; is_16 = 1'b0; cold_en = 1'b0; scrub = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    rd(1, 1); #1;
    check("rst_busy", 64'(scrub_busy), 64'd0);
    check("rst_err",  64'(cold_err),   64'd0);
    check("rst_cnt",  64'(err_cnt),    64'd0);
    check("rst_addr", 64'(err_addr),   64'd0);
    check("rst_rd",   rdata[63:0],     64'd0);

    // Hot write without authorization
    waddr = 1; wdata = 64'h1234_5678_9ABC_DEF0; regwrite = 1'b1; tick();
    regwrite = 1'b0; rd(1, 1); #1;
    check("hot_p0", rdata[63:0],   64'h1234_5678_9ABC_DEF0);
    check("hot_p1", rdata[127:64], 64'h1234_5678_9ABC_DEF0);
    check("hot_noerr", 64'(cold_err), 64'd0);

    // Unauthorized cold write
    waddr = 4; wdata = 64'hDEAD_BEEF_DEAD_BEEF; regwrite = 1'b1; tick();
    regwrite = 1'b0;
    check("cold_err",  64'(cold_err), 64'd1);
    check("cold_cnt",  64'(err_cnt),  64'd1);
    check("cold_addr", 64'(err_addr), 64'd4);
    cold_en = 1'b1; rvalid = 2'b01; rd(4, 0); #1;
    check("cold_drop", rdata[63:0], 64'd0);
    rvalid = 2'b00;

    // Authorized cold write and read
    waddr = 4; wdata = 64'hCAFE_BABE_CAFE_BABE; regwrite = 1'b1; tick();
    regwrite = 1'b0; rd(4, 4); #1;
    check("cold_auth_rd", rdata[63:0], 64'hCAFE_BABE_CAFE_BABE);
    cold_en = 1'b0; #1;
    check("cold_gate_rd", rdata[127:64], 64'd0);
    tick();
    check("cold_norvalid_cnt", 64'(err_cnt), 64'd1);

    // Compressed mode
    is_16 = 1'b1; waddr = 0; wdata = 64'hABAB_ABAB_ABAB_ABAB; regwrite = 1'b1; tick();
    waddr = 5; wdata = 64'h1313_1313_1313_1313; cold_en = 1'b1; tick();
    regwrite = 1'b0; rd(0, 5); #1;
    check("c16_rd_x8",  rdata[63:0],   64'hABAB_ABAB_ABAB_ABAB);
    check("c16_rd_x13", rdata[127:64], 64'h1313_1313_1313_1313);
    is_16 = 1'b0; rd(8, 13); #1;
    check("n_rd_x8",  rdata[63:0],   64'hABAB_ABAB_ABAB_ABAB);
    check("n_rd_x13", rdata[127:64], 64'h1313_1313_1313_1313);
    cold_en = 1'b0; tick();
    check("c16_cnt", 64'(err_cnt), 64'd1);

    // Bypass
    waddr = 6; wdata = 64'hE1E2_E3E4_F1F2_F3F4; regwrite = 1'b1; rd(1, 6); #1;
    check("byp_p1", rdata[127:64], 64'hE1E2_E3E4_F1F2_F3F4);
    check("byp_p0", rdata[63:0],   64'h1234_5678_9ABC_DEF0);
    tick(); regwrite = 1'b0; #1;
    check("byp_stored", rdata[127:64], 64'hE1E2_E3E4_F1F2_F3F4);

    // Clear
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_err",  64'(cold_err), 64'd0);
    check("clr_cnt",  64'(err_cnt),  64'd0);
    check("clr_addr", 64'(err_addr), 64'd0);

    // Priority (write beats read) and saturation
    waddr = 7; wdata = 64'h7777; regwrite = 1'b1; rd(12, 3); rvalid = 2'b01; tick();
    regwrite = 1'b0; rvalid = 2'b10;
    check("prio_cnt",  64'(err_cnt),  64'd1);
    check("prio_addr", 64'(err_addr), 64'd7);
    repeat (299) tick();
    check("sat_cnt",  64'(err_cnt),  64'd255);
    check("sat_err",  64'(cold_err), 64'd1);
    check("sat_addr", 64'(err_addr), 64'd7);
    rvalid = 2'b00; cold_en = 1'b1; rd(7, 7); #1;
    check("x7_dropped", rdata[63:0], 64'd0);
    cold_en = 1'b0;

    // Clear coincident with violation; port 0 beats port 1
    err_clr = 1'b1; rvalid = 2'b11; rd(12, 3); tick();
    err_clr = 1'b0; rvalid = 2'b00;
    check("clrv_cnt",  64'(err_cnt),  64'd1);
    check("clrv_err",  64'(cold_err), 64'd1);
    check("clrv_addr", 64'(err_addr), 64'd12);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Scrub setup
    cold_en = 1'b1; regwrite = 1'b1;
    waddr = 3;  wdata = 64'hABCD_EF01_2345_6789; tick();
    waddr = 31; wdata = 64'h3131_3131_3131_3131; tick();
    waddr = 1;  wdata = 64'd1; tick();
    regwrite = 1'b0; cold_en = 1'b0;

    scrub = 1'b1; tick(); scrub = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!scrub_busy) break;
      busy_cycles++;
      if (i == 20) begin
        cold_en = 1'b1; regwrite = 1'b1; waddr = 3; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        scrub = 1'b1; rd(31, 1); #1;
        check("scrub_cold_rd", rdata[63:0],   64'd0);
        check("scrub_hot_rd",  rdata[127:64], 64'd1);
      end
      tick();
      regwrite = 1'b0; cold_en = 1'b0; scrub = 1'b0;
    end
    check("scrub_busy_len", 64'(busy_cycles), 64'd31);
    check("scrub_noerr", 64'(cold_err), 64'd0);
    cold_en = 1'b1; rd(3, 1); #1;
    check("scrub_x3", rdata[63:0],   64'd0);
    check("scrub_x1", rdata[127:64], 64'd1);
    rd(31, 8); #1;
    check("scrub_x31", rdata[63:0],   64'd0);
    check("scrub_x8",  rdata[127:64], 64'hABAB_ABAB_ABAB_ABAB);
    cold_en = 1'b0;

    // Reset mid-scrub
    rvalid = 2'b01; rd(3, 0); tick(); rvalid = 2'b00;
    check("pre_rst_cnt", 64'(err_cnt), 64'd1);
    scrub = 1'b1; tick(); scrub = 1'b0;
    repeat (9) tick();
    check("pre_rst_busy", 64'(scrub_busy), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_busy", 64'(scrub_busy), 64'd0);
    check("mrst_err",  64'(cold_err),   64'd0);
    check("mrst_cnt",  64'(err_cnt),    64'd0);
    check("mrst_addr", 64'(err_addr),   64'd0);
    cold_en = 1'b1; rd(1, 8); #1;
    check("mrst_x1", rdata[63:0],   64'd0);
    check("mrst_x8", rdata[127:64], 64'd0);
    tick();
    check("mrst_idle", 64'(scrub_busy), 64'd0);

    // x0 write discarded
    waddr = 0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; regwrite = 1'b1; rd(0, 0); #1;
    check("x0_nobyp", rdata[63:0], 64'd0);
    tick(); regwrite = 1'b0; #1;
    check("x0_rd",    rdata[127:64], 64'd0);
    check("x0_noerr", 64'(cold_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_hc_param.md
# regfile_hc_param

Parametrised hot/cold integer register file for the core's decode/writeback boundary: N combinational read ports and one write port, plus a 16-bit compressed-instruction address mode. Registers outside the configurable hot set are cold and need `cold_en_i` for every access. The block adds violation logging (sticky flag, saturating counter, first-fault address) and a multi-cycle cold-register scrub sequencer. It replaces the fixed 64-bit, 2-port hot/cold register file.

## Interface
- `XLEN`, 64, data width.
- `NREGS`, 32, register count. Power of two, ≥16. AW = log2(NREGS).
- `NRPORTS`, 2, number of read ports.
- `HOT_MASK`, 32'h0000_0767, bit i = 1 marks register i hot (x0,x1,x2,x5,x6,x8,x9,x10). All other registers are cold.
- `BYPASS`, 1, 1 = a same-cycle write is forwarded to matching read ports.
- `ERRW`, 8, error counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `raddr_i` in NRPORTS*AW: read addresses, port p at [p*AW +: AW].
- `rvalid_i` in NRPORTS: per-port read qualifier. Used only for violation detection.
- `rdata_o` out NRPORTS*XLEN: read data, port p at [p*XLEN +: XLEN].
- `waddr_i` in AW: write address.
- `wdata_i` in XLEN: write data.
- `regwrite_i` in 1: write enable.
- `is_16_i` in 1: compressed mode. Applies to all read and write addresses in the cycle.
- `cold_en_i` in 1: cold-access authorization for the current cycle.
- `scrub_i` in 1: start cold scrub (pulse).
- `scrub_busy_o` out 1: scrub in progress.
- `err_clr_i` in 1: clear the violation log.
- `cold_err_o` out 1: sticky violation flag.
- `err_cnt_o` out ERRW: count of violation cycles, saturating.
- `err_addr_o` out AW: effective address of the first violation since the last clear.

## Operation
- Effective address: when `is_16_i`=1, eff = 8 + addr[2:0]; otherwise eff = addr. Hot/cold classification and all checks use eff.
- x0 (eff=0) always reads 0. Writes to x0 are discarded without error. In compressed mode eff is never 0.
- Read, port p: output is 0 if eff=0, or if eff is cold and (`cold_en_i`=0 or `scrub_busy_o`=1). Otherwise the output is the register contents. With BYPASS=1, a write that commits this cycle to the same eff returns `wdata_i`.
- Write: commits when `regwrite_i`=1, eff≠0, and (eff is hot, or `cold_en_i`=1 and scrub is idle).
- Violation: an unauthorized access with `cold_en_i`=0. Either `regwrite_i`=1 to a cold eff, or `rvalid_i[p]`=1 on a cold eff.
  - A cold write dropped only because a scrub is running is not a violation.
- Violation cycle: `cold_err_o` sets. `err_cnt_o` increments by 1 per cycle, regardless of how many ports violate, and saturates at 2^ERRW−1.
- First-fault capture: if `cold_err_o` was 0, `err_addr_o` captures the violating eff. Priority is write port, then read port 0, 1, and so on.
- `err_clr_i`: zeroes the flag, counter and address. If a violation occurs in the same cycle, the violation is logged as the first after the clear (cnt=1).
- Scrub FSM, IDLE → SCRUB:
  - Leaves IDLE on `scrub_i`=1. Index starts at 1.
  - In SCRUB, each cycle zeroes register[index] if it is cold, then increments the index.
  - After index NREGS−1 is processed, returns to IDLE.
  - `scrub_i` is ignored while in SCRUB.
  - Hot writes and hot reads proceed normally during a scrub.

## Timing
- Reads are combinational from the address to `rdata_o` (zero cycles).
- Writes are visible on a read from the cycle after commit, or the same cycle with BYPASS=1.
- `scrub_busy_o` rises one cycle after `scrub_i` and stays high for exactly NREGS−1 cycles.
- Log outputs update on the edge following the violating cycle.
- Reset: all registers 0, FSM IDLE, `scrub_busy_o`=0, `cold_err_o`=0, `err_cnt_o`=0, `err_addr_o`=0.
- Reset during a scrub aborts it. The next cycle is IDLE with all registers zero.

## Test plan
- Hot write/read: write x1=64'h123456789ABCDEF0 with `cold_en_i`=0. Both ports read x1 → 64'h123456789ABCDEF0 and no error is logged.
- Cold authorization:
  - Write x4=64'hDEADBEEFDEADBEEF with `cold_en_i`=0 → write dropped, `cold_err_o`=1, cnt=1, `err_addr_o`=4.
  - Authorized write 64'hCAFEBABECAFEBABE, then authorized read → 64'hCAFEBABECAFEBABE.
- Compressed mode:
  - `is_16_i`=1, waddr=0, data 64'hABAB… → x8 written.
  - waddr=5 with `cold_en_i`=1 → x13 written.
  - Reading addr 0 on port 0 and addr 8 in normal mode → both return 64'hABAB…
- Bypass and saturation:
  - Write x6 while reading x6 on port 1 → same-cycle 64'hE1E2E3E4F1F2F3F4.
  - 300 consecutive violation cycles → cnt=255.
  - `err_clr_i` asserted together with a violation → cnt=1.
- Scrub:
  - Set x3=64'hABCDEF0123456789 and x1=1, then pulse `scrub_i` → busy for 31 cycles.
  - During the scrub, a cold write is dropped without error and an authorized cold read returns 0.
  - After the scrub, x3=0 and x1=1.
- Reset: assert `rst` at scrub cycle 10 → next cycle busy=0, all reads 0, log cleared. A write to x0 afterwards still reads 0.
